// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory responder for the multi-cycle MIPS core.
// Boots from a valid/ready loader stream, then serves core reads/writes with error flags and counters.
module mips_mem_responder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      adr_to_write,
  input  logic [31:0]      data_to_mem,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [31:0]      mem,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_run,
  output logic             misalign_err,
  output logic             range_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) * 33'd4;

  state_t                    state_reg, state_next;
  logic [ADDR_W-1:0]         ptr_reg, ptr_next;
  logic                      misalign_err_reg, range_err_reg;
  logic [31:0]               ram [DEPTH];

  logic                      ld_fire;
  logic                      in_range;
  logic                      core_access;
  logic                      core_wr;
  logic [ADDR_W-1:0]         word_idx;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_waddr;
  logic [31:0]               ram_wdata;
  logic [1:0]                cnt_inc;
  logic [1:0][CNT_W-1:0]     cnt_all;

  assign word_idx    = adr_to_write[ADDR_W+1:2];
  assign in_range    = {1'b0, adr_to_write} < BYTE_LIMIT;
  assign core_access = cpu_run & (mem_read | mem_write);
  assign core_wr     = cpu_run & mem_write & in_range;

  // Boot FSM: LOAD accepts loader words until ld_last or a full array, then RUN forever.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    ld_ready   = 1'b0;
    cpu_run    = 1'b0;
    ld_fire    = 1'b0;
    case (state_reg)
      LOAD: begin
        ld_ready = 1'b1;
        ld_fire  = ld_valid;
        if (ld_valid) begin
          ptr_next = ptr_reg + 1'b1;
          if (ld_last || (ptr_reg == ADDR_W'(DEPTH - 1))) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        cpu_run = 1'b1;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LOAD;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Loader and core never write in the same state, so one write port is shared.
  assign ram_we    = ld_fire | core_wr;
  assign ram_waddr = ld_fire ? ptr_reg : word_idx;
  assign ram_wdata = ld_fire ? ld_data : data_to_mem;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  assign mem = (cpu_run && mem_read && in_range) ? ram[word_idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err_reg <= 1'b0;
      range_err_reg    <= 1'b0;
    end else if (core_access) begin
      if (adr_to_write[1:0] != 2'b00) begin
        misalign_err_reg <= 1'b1;
      end
      if (!in_range) begin
        range_err_reg <= 1'b1;
      end
    end
  end

  assign misalign_err = misalign_err_reg;
  assign range_err    = range_err_reg;

  // Index 0 counts reads, index 1 counts writes; both saturate at all-ones.
  assign cnt_inc = {mem_write, mem_read} & {2{cpu_run & in_range}};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
          count_reg <= count_reg + 1'b1;
        end
      end
      assign cnt_all[gi] = count_reg;
    end
  endgenerate

  assign rd_count = cnt_all[0];
  assign wr_count = cnt_all[1];

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: a full-size instance driven against a behavioural model,
// plus a tiny instance (4 words, 3-bit counters) for the full-array and saturation cases.
module tb_mips_mem_responder;

  localparam int DEPTH = 1024;

  localparam int S_LDRDY  = 0;
  localparam int S_RUN    = 1;
  localparam int S_MIS    = 2;
  localparam int S_RNG    = 3;
  localparam int S_RDC    = 4;
  localparam int S_WRC    = 5;
  localparam int S_LDRDY4 = 6;
  localparam int S_RUN4   = 7;
  localparam int S_MEM4   = 8;
  localparam int S_RDC4   = 9;

  typedef struct {
    int          sig;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, wdata, mem, ld_data;
  logic        rd, wr, ld_valid, ld_last, ld_ready, cpu_run, mis, rng;
  logic [15:0] rdc, wrc;

  logic [31:0] s_adr, s_wdata, s_mem, s_ld_data;
  logic        s_rd, s_wr, s_ld_valid, s_ld_last, s_ld_ready, s_cpu_run, s_mis, s_rng;
  logic [2:0]  s_rdc, s_wrc;

  mips_mem_responder #(.DEPTH(DEPTH), .ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .adr_to_write(adr), .data_to_mem(wdata),
    .mem_read(rd), .mem_write(wr), .mem(mem),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_run(cpu_run), .misalign_err(mis), .range_err(rng),
    .rd_count(rdc), .wr_count(wrc)
  );

  mips_mem_responder #(.DEPTH(4), .ADDR_W(2), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .adr_to_write(s_adr), .data_to_mem(s_wdata),
    .mem_read(s_rd), .mem_write(s_wr), .mem(s_mem),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
    .cpu_run(s_cpu_run), .misalign_err(s_mis), .range_err(s_rng),
    .rd_count(s_rdc), .wr_count(s_wrc)
  );

  // Reference model of the full-size instance
  logic [31:0] m_mem [DEPTH];
  bit          m_run, m_mis, m_rng;
  int          m_ptr, m_rdc, m_wrc;

  chk_t        st_q[$];
  logic [31:0] rd_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          done   = 1'b0;

  function automatic string sig_name(int s);
    case (s)
      S_LDRDY:  return "ld_ready";
      S_RUN:    return "cpu_run";
      S_MIS:    return "misalign_err";
      S_RNG:    return "range_err";
      S_RDC:    return "rd_count";
      S_WRC:    return "wr_count";
      S_LDRDY4: return "small_ld_ready";
      S_RUN4:   return "small_cpu_run";
      S_MEM4:   return "small_mem";
      S_RDC4:   return "small_rd_count";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] get_sig(int s);
    case (s)
      S_LDRDY:  return {31'b0, ld_ready};
      S_RUN:    return {31'b0, cpu_run};
      S_MIS:    return {31'b0, mis};
      S_RNG:    return {31'b0, rng};
      S_RDC:    return {16'b0, rdc};
      S_WRC:    return {16'b0, wrc};
      S_LDRDY4: return {31'b0, s_ld_ready};
      S_RUN4:   return {31'b0, s_cpu_run};
      S_MEM4:   return s_mem;
      S_RDC4:   return {29'b0, s_rdc};
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push(int s, logic [31:0] e);
    chk_t c;
    c.sig = s;
    c.exp = e;
    st_q.push_back(c);
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_ptr = 0; m_mis = 1'b0; m_rng = 1'b0; m_rdc = 0; m_wrc = 0;
  endtask

  // Called just after a rising edge with inputs applied; queues this cycle's
  // expectations, then advances the model across the next edge.
  task automatic step();
    int idx;
    bit inr;
    idx = int'(adr[11:2]);
    inr = (adr < 32'(DEPTH * 4));
    push(S_LDRDY, {31'b0, !m_run});
    push(S_RUN,   {31'b0, m_run});
    push(S_MIS,   {31'b0, m_mis});
    push(S_RNG,   {31'b0, m_rng});
    push(S_RDC,   32'(m_rdc));
    push(S_WRC,   32'(m_wrc));
    if (rd) rd_q.push_back((m_run && inr) ? m_mem[idx] : 32'h0);
    @(posedge clk);
    if (rst) begin
      if (!m_run) begin
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          if (ld_last || m_ptr == DEPTH - 1) m_run = 1'b1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end else begin
        if ((rd || wr) && adr[1:0] != 2'b00) m_mis = 1'b1;
        if ((rd || wr) && !inr) m_rng = 1'b1;
        if (wr && inr) m_mem[idx] = wdata;
        if (rd && inr && m_rdc < 65535) m_rdc++;
        if (wr && inr && m_wrc < 65535) m_wrc++;
      end
    end
    #1;
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    s_rd = 1'b0; s_ld_valid = 1'b0; s_ld_last = 1'b0;
  endtask

  task automatic access(bit r, bit w, logic [31:0] a, logic [31:0] d);
    idle();
    rd = r; wr = w; adr = a; wdata = d;
    step();
  endtask

  task automatic load(logic [31:0] d, bit last);
    idle();
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    step();
  endtask

  // Monitor: compares every queued status expectation and every read response.
  chk_t        mon_c;
  logic [31:0] mon_act, mon_exp;
  always @(negedge clk) begin
    while (st_q.size() > 0) begin
      mon_c   = st_q.pop_front();
      mon_act = get_sig(mon_c.sig);
      checks++;
      if (mon_act !== mon_c.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h t=%0t", sig_name(mon_c.sig), mon_act, mon_c.exp, $time);
      end
    end
    if (rd) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_queue_empty actual=%h t=%0t", mem, $time);
      end else begin
        mon_exp = rd_q.pop_front();
        $display("read adr=%h mem=%h expected=%h", adr, mem, mon_exp);
        if (mem !== mon_exp) begin
          errors++;
          $display("FAIL read_data actual=%h required=%h adr=%h", mem, mon_exp, adr);
        end
      end
    end else begin
      checks++;
      if (mem !== 32'h0) begin
        errors++;
        $display("FAIL idle_mem actual=%h required=00000000 t=%0t", mem, $time);
      end
    end
    if (done) begin
      checks++;
      if (rd_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_reads actual=%0d required=0", rd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    adr = '0; wdata = '0; ld_data = '0;
    s_adr = '0; s_wdata = '0; s_wr = 1'b0; s_ld_data = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Ten cycles in LOAD: core reads return 0, writes and errors are ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        push(S_LDRDY4, 32'd1);
        push(S_RUN4, 32'd0);
      end
      access(1'b1, 1'($urandom_range(0, 1)), (i % 2 == 0) ? 32'h13 : 32'h2000, $urandom);
    end

    // Tiny instance: six words, no ld_last; only four are taken
    for (int k = 0; k < 6; k++) begin
      idle();
      s_ld_valid = 1'b1; s_ld_data = 32'h100 + 32'(k); s_ld_last = 1'b0;
      push(S_LDRDY4, (k < 4) ? 32'd1 : 32'd0);
      push(S_RUN4, (k >= 4) ? 32'd1 : 32'd0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      s_rd = 1'b1; s_adr = 32'(k * 4);
      push(S_MEM4, 32'h100 + 32'(k));
      step();
    end
    for (int j = 0; j < 6; j++) begin
      idle();
      s_rd = 1'b1; s_adr = 32'h0;
      push(S_MEM4, 32'h100);
      push(S_RDC4, (4 + j > 7) ? 32'd7 : 32'(4 + j));
      step();
    end
    idle();
    push(S_RDC4, 32'd7);
    step();

    // Boot the main instance with four words
    load(32'h11, 1'b0);
    load(32'h22, 1'b0);
    load(32'h33, 1'b0);
    load(32'h44, 1'b1);
    idle(); step();
    for (int k = 0; k < 4; k++) access(1'b1, 1'b0, 32'(k * 4), '0);
    idle(); step();

    // Write, read-back, and same-cycle read/write
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, '0);
    access(1'b1, 1'b1, 32'h10, 32'h1);
    access(1'b1, 1'b0, 32'h10, '0);

    // Misaligned and out-of-range accesses
    access(1'b1, 1'b0, 32'h13, '0);
    access(1'b0, 1'b1, 32'(DEPTH * 4), 32'h55);
    access(1'b1, 1'b0, 32'(DEPTH * 4), '0);
    idle(); step();

    // Randomised traffic over a small known window plus out-of-range hits
    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 4000)) : ($urandom | 32'h8000_0000);
      else
        a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Asynchronous reset mid-run, partial reload, reset mid-load, reload
    idle();
    rst = 1'b0; model_reset();
    step();
    rst = 1'b1;
    load(32'hA0, 1'b0);
    load(32'hA1, 1'b0);
    idle();
    rst = 1'b0; model_reset();
    step();
    rst = 1'b1;
    idle(); step();
    load(32'hB0, 1'b1);
    idle(); step();
    access(1'b1, 1'b0, 32'h0, '0);
    access(1'b1, 1'b0, 32'h4, '0);
    idle(); step();

    done = 1'b1;
  end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the multi-cycle MIPS core's unified instruction/data memory bus. It serves the core's read and write strobes from a single word array and boots through a valid/ready loader stream that fills the array before the core is released. It flags misaligned and out-of-range accesses and keeps access counters for bench and debug use. The block sits beside the core at top level: the core's address, write-data and strobe outputs drive it, and its read-data output drives the core's memory input.

## Interface
- DEPTH, 1024: number of 32-bit words in the array; must be a power of two.
- ADDR_W, 10: word-index width, equal to log2(DEPTH).
- CNT_W, 16: width of the access counters.

- clk  in  1  single clock; every state element updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- adr_to_write  in  32  byte address from the core, used for both reads and writes.
- data_to_mem  in  32  write data from the core.
- mem_read  in  1  core read strobe.
- mem_write  in  1  core write strobe.
- mem  out  32  read data to the core (combinational).
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks the final loader word; sampled only on a handshake.
- ld_ready  out  1  loader may transfer.
- cpu_run  out  1  boot complete; top level holds the core in reset while this is 0.
- misalign_err  out  1  sticky flag: an access had adr_to_write[1:0] != 0.
- range_err  out  1  sticky flag: an access had an address >= DEPTH*4.
- rd_count  out  CNT_W  count of accepted read cycles, saturating.
- wr_count  out  CNT_W  count of accepted write cycles, saturating.

## Operation
- State machine has two states:
  - LOAD: entered on reset.
  - RUN: entered from LOAD after the final loader word; no exit except reset.
- LOAD state:
  - ld_ready = 1.
  - A handshake (ld_valid & ld_ready) writes ld_data to array[ptr] and increments ptr.
  - ptr is ADDR_W bits and resets to 0.
  - The machine moves to RUN on a handshake with ld_last = 1, or on a handshake when ptr == DEPTH-1. The latter case is a full array: remaining loader words are refused.
- RUN state: ld_ready = 0 and cpu_run = 1.
- Core accesses in LOAD are ignored:
  - mem = 0.
  - Writes are dropped.
  - Counters and error flags are not updated.
- Core accesses in RUN:
  - Word index = adr_to_write[ADDR_W+1:2].
  - In range means adr_to_write < DEPTH*4.
  - Read: mem = array[index] when mem_read is 1 and the address is in range; otherwise mem = 0.
  - Write: array[index] <= data_to_mem on the edge when mem_write is 1 and the address is in range.
  - Misaligned access: the low address bits are ignored, the access still proceeds, and misalign_err sets.
  - Out-of-range access: reads return 0, writes are dropped, and range_err sets.
  - Error flags are evaluated only in cycles where mem_read or mem_write is 1.
  - Both strobes in the same cycle: the write commits at the edge; mem shows pre-edge data; both counters increment.
- Counters:
  - rd_count increments in every RUN cycle with mem_read = 1 and an in-range address.
  - wr_count increments in every RUN cycle with mem_write = 1 and an in-range address.
  - Both counters hold at all-ones once they saturate.
- The array is never cleared by reset. Only the state, ptr, flags and counters reset.

## Timing
- Reset values:
  - State = LOAD, ptr = 0.
  - ld_ready = 1, cpu_run = 0.
  - mem = 0.
  - misalign_err = 0, range_err = 0.
  - rd_count = 0, wr_count = 0.
- Asserting rst mid-load or mid-run immediately returns the block to LOAD with ptr = 0 and drops cpu_run asynchronously. The array keeps its contents.
- Read latency is zero: mem follows adr_to_write and mem_read combinationally in the same cycle.
- A word written at edge N is visible on mem from cycle N+1.
- Loader throughput is one word per cycle. ld_ready never depends combinationally on ld_valid.
- Final handshake at edge N: ld_ready falls and cpu_run rises after edge N.
- Error flags and counters update at the edge that ends the access cycle.

## Test plan
- Reset with ld_valid = 0: ld_ready = 1, cpu_run = 0, mem = 0, and both counters and both flags are 0 for a full 10-cycle check.
- Load 4 words 0x11,0x22,0x33,0x44 with ld_last on the 4th word -> cpu_run = 1 the cycle after; reading byte addresses 0x0/0x4/0x8/0xC returns the 4 words; rd_count = 4.
- In RUN, write 0xDEADBEEF to 0x10 with mem_write = 1 for one cycle, then read 0x10 -> 0xDEADBEEF; wr_count = 1. A simultaneous read/write to 0x10 of 0x1 returns 0xDEADBEEF in that cycle and 0x1 in the next.
- Read from 0x13 -> returns the word at 0x10 and misalign_err = 1. Write to DEPTH*4 -> dropped, range_err = 1, wr_count unchanged, and a read of that address returns 0.
- With DEPTH = 4, stream 6 words with no ld_last -> only 4 words are accepted, ld_ready = 0 after the 4th handshake, and cpu_run = 1.
- Pulse rst low after 2 loader words -> ld_ready = 1, cpu_run = 0, ptr restarts at 0. Reloading 1 word with ld_last overwrites word 0, and word 1 keeps its earlier value.
